bitstream_unpacker: RTL

BITSTREAM_UNPACKER -- requirements
Module: bitstream_unpacker

---
 rtl/bitstream_unpacker_if.sv | 38 +++
 rtl/bitstream_unpacker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_unpacker_if.sv
// Encoder-side fields and byte-stream side of the bitstream unpacker.
// The master drives the encoder fields and out_ready; the slave is the unpacker.
interface bitstream_unpacker_if #(
    parameter int BITSTREAM_WIDTH = 8,
    parameter int FIFO_DEPTH      = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [BITSTREAM_WIDTH-1:0] in_bit_1;
    logic [BITSTREAM_WIDTH-1:0] in_bit_2;
    logic [BITSTREAM_WIDTH-1:0] in_bit_3;
    logic [BITSTREAM_WIDTH-1:0] in_bit_4;
    logic [BITSTREAM_WIDTH-1:0] in_bit_5;
    logic [2:0]                 in_flag_bitstream;
    logic                       in_flag_last;
    logic [BITSTREAM_WIDTH-1:0] out_byte;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       out_done;
    logic [LEVEL_W-1:0]         fifo_level;
    logic                       overflow;
    logic                       protocol_error;

    modport master (
        output in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
        output in_flag_bitstream, in_flag_last, out_ready,
        input  out_byte, out_valid, out_last, out_done,
        input  fifo_level, overflow, protocol_error
    );

    modport slave (
        input  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
        input  in_flag_bitstream, in_flag_last, out_ready,
        output out_byte, out_valid, out_last, out_done,
        output fifo_level, overflow, protocol_error
    );
endinterface

// File: rtl/bitstream_unpacker.sv
// Buffers packed encoder packets in a FIFO and serialises each one into a
// valid/ready byte stream, expanding run-length fields along the way.
module bitstream_unpacker #(
    parameter int BITSTREAM_WIDTH = 8,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                top_clk,
    input  logic                top_reset,
    bitstream_unpacker_if.slave bus
);
    localparam int W  = BITSTREAM_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 5 * W + 4;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE    = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [W-1:0]  CNT_ONE    = W'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] EMIT_B1  = 3'd2;
    localparam logic [2:0] EMIT_RUN = 3'd3;
    localparam logic [2:0] EMIT_B4  = 3'd4;
    localparam logic [2:0] EMIT_B5  = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    localparam logic [2:0] STEP_HOLD = 3'd0;
    localparam logic [2:0] STEP_RUN  = 3'd1;
    localparam logic [2:0] STEP_B4   = 3'd2;
    localparam logic [2:0] STEP_B5   = 3'd3;
    localparam logic [2:0] STEP_END  = 3'd4;

    logic [EW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [2:0]    state_r, state_nxt_s, step_s, in_flag_s, rd_flag_s;
    logic [W-1:0]  out_byte_r, byte_nxt_s;
    logic          out_valid_r, valid_nxt_s, out_last_r, last_nxt_s, out_done_r, done_nxt_s;
    logic          overflow_r, protocol_error_r;
    logic [W-1:0]  w_run_r, w_b4_r, w_b5_r, w_cnt_r, cnt_nxt_s;
    logic          w_has4_r, w_has5_r, w_last_r;
    logic          push_req_s, push_s, pop_s, full_s, empty_s, hs_s, rd_last_s;
    logic [EW-1:0] wr_entry_s, rd_entry_s;
    logic [W-1:0]  rd_b1_s, rd_b2_s, rd_b3_s, rd_b4_s, rd_b5_s;
    logic [W-1:0]  n_cnt_s, n_b4_s;
    logic          n_has4_s, n_has5_s;

    // Flag 4 is stored as an empty packet; it only reaches the FIFO with a last marker.
    assign in_flag_s  = bus.in_flag_bitstream;
    assign full_s     = (level_r == LEVEL_FULL);
    assign empty_s    = (level_r == {LW{1'b0}});
    assign pop_s      = (state_r == LOAD);
    assign push_req_s = bus.in_flag_last || ((in_flag_s != 3'd0) && (in_flag_s != 3'd4));
    assign push_s     = push_req_s && (!full_s || pop_s);
    assign wr_entry_s = {bus.in_flag_last, (in_flag_s == 3'd4) ? 3'd0 : in_flag_s,
                         bus.in_bit_5, bus.in_bit_4, bus.in_bit_3, bus.in_bit_2, bus.in_bit_1};
    assign hs_s       = out_valid_r && bus.out_ready;

    assign rd_entry_s = mem_r[rd_ptr_r];
    assign rd_b1_s    = rd_entry_s[0 +: W];
    assign rd_b2_s    = rd_entry_s[W +: W];
    assign rd_b3_s    = rd_entry_s[2*W +: W];
    assign rd_b4_s    = rd_entry_s[3*W +: W];
    assign rd_b5_s    = rd_entry_s[4*W +: W];
    assign rd_flag_s  = rd_entry_s[5*W +: 3];
    assign rd_last_s  = rd_entry_s[EW-1];

    // Recast every format as: bit_1, a run of bit_2, then optional tail bytes (B4, B5).
    always_comb begin
        n_cnt_s  = {W{1'b0}};
        n_b4_s   = rd_b4_s;
        n_has4_s = 1'b0;
        n_has5_s = 1'b0;
        case (rd_flag_s)
            3'd2: n_cnt_s = CNT_ONE;
            3'd3: begin
                n_cnt_s  = CNT_ONE;
                n_b4_s   = rd_b3_s;
                n_has4_s = 1'b1;
            end
            3'd5: n_cnt_s = rd_b3_s;
            3'd6: begin
                n_cnt_s  = rd_b3_s;
                n_has4_s = 1'b1;
            end
            3'd7: begin
                n_cnt_s  = rd_b3_s;
                n_has4_s = 1'b1;
                n_has5_s = 1'b1;
            end
            default: n_cnt_s = {W{1'b0}};
        endcase
    end

    // Which byte follows the one currently accepted (HOLD while stalled).
    always_comb begin
        step_s = STEP_HOLD;
        case (state_r)
            EMIT_B1, EMIT_RUN: step_s = !hs_s ? STEP_HOLD :
                                        (w_cnt_r != {W{1'b0}}) ? STEP_RUN :
                                        w_has4_r ? STEP_B4 :
                                        w_has5_r ? STEP_B5 : STEP_END;
            EMIT_B4: step_s = !hs_s ? STEP_HOLD : (w_has5_r ? STEP_B5 : STEP_END);
            EMIT_B5: step_s = hs_s ? STEP_END : STEP_HOLD;
            default: step_s = STEP_HOLD;
        endcase
    end

    // Next state and next registered output values.
    always_comb begin
        state_nxt_s = state_r;
        byte_nxt_s  = out_byte_r;
        valid_nxt_s = out_valid_r;
        last_nxt_s  = out_last_r;
        done_nxt_s  = 1'b0;
        cnt_nxt_s   = w_cnt_r;
        case (state_r)
            IDLE: state_nxt_s = empty_s ? IDLE : LOAD;
            LOAD: begin
                cnt_nxt_s = n_cnt_s;
                if (rd_flag_s == 3'd0) begin
                    state_nxt_s = DONE;
                    valid_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = EMIT_B1;
                    byte_nxt_s  = rd_b1_s;
                    valid_nxt_s = 1'b1;
                    last_nxt_s  = rd_last_s && (n_cnt_s == {W{1'b0}}) && !n_has4_s && !n_has5_s;
                end
            end
            DONE: state_nxt_s = empty_s ? IDLE : LOAD;
            EMIT_B1, EMIT_RUN, EMIT_B4, EMIT_B5: state_nxt_s = state_r;
            default: begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end
        endcase
        case (step_s)
            STEP_RUN: begin
                state_nxt_s = EMIT_RUN;
                byte_nxt_s  = w_run_r;
                cnt_nxt_s   = w_cnt_r - CNT_ONE;
                last_nxt_s  = w_last_r && (w_cnt_r == CNT_ONE) && !w_has4_r && !w_has5_r;
            end
            STEP_B4: begin
                state_nxt_s = EMIT_B4;
                byte_nxt_s  = w_b4_r;
                last_nxt_s  = w_last_r && !w_has5_r;
            end
            STEP_B5: begin
                state_nxt_s = EMIT_B5;
                byte_nxt_s  = w_b5_r;
                last_nxt_s  = w_last_r;
            end
            STEP_END: begin
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
                if (w_last_r) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = empty_s ? IDLE : LOAD;
                end
            end
            default: cnt_nxt_s = cnt_nxt_s;
        endcase
    end

    // FSM, output registers, working registers and sticky status.
    always_ff @(posedge top_clk) begin
        if (!top_reset) begin
            state_r          <= IDLE;
            out_byte_r       <= {W{1'b0}};
            out_valid_r      <= 1'b0;
            out_last_r       <= 1'b0;
            out_done_r       <= 1'b0;
            w_cnt_r          <= {W{1'b0}};
            w_run_r          <= {W{1'b0}};
            w_b4_r           <= {W{1'b0}};
            w_b5_r           <= {W{1'b0}};
            w_has4_r         <= 1'b0;
            w_has5_r         <= 1'b0;
            w_last_r         <= 1'b0;
            overflow_r       <= 1'b0;
            protocol_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_byte_r  <= byte_nxt_s;
            out_valid_r <= valid_nxt_s;
            out_last_r  <= last_nxt_s;
            out_done_r  <= done_nxt_s;
            w_cnt_r     <= cnt_nxt_s;
            if (pop_s) begin
                w_run_r  <= rd_b2_s;
                w_b4_r   <= n_b4_s;
                w_b5_r   <= rd_b5_s;
                w_has4_r <= n_has4_s;
                w_has5_r <= n_has5_s;
                w_last_r <= rd_last_s;
            end
            if (push_req_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
            if (in_flag_s == 3'd4) begin
                protocol_error_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge top_clk) begin
        if (!top_reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge top_clk) begin
        if (top_reset && push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    assign bus.out_byte       = out_byte_r;
    assign bus.out_valid      = out_valid_r;
    assign bus.out_last       = out_last_r;
    assign bus.out_done       = out_done_r;
    assign bus.fifo_level     = level_r;
    assign bus.overflow       = overflow_r;
    assign bus.protocol_error = protocol_error_r;
endmodule
